// File: rtl/common_param.sv
// Shared MIPS encoding constants used across the core.
// R-type funct codes for the HI/LO instruction class.
package common_param;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_seq_pkg.sv
// Types and defaults for the multiply/divide sequencer.
// The DIV state exists only when MULDIV_DIV_EN is defined.
package muldiv_seq_pkg;

  localparam int XLEN_D = 32;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX
  } state_t;
`endif

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-side handshake bundle for the HI/LO sequencer.
// master = EX stage, slave = muldiv_seq.
interface muldiv_seq_if #(
  parameter int XLEN = muldiv_seq_pkg::XLEN_D
);

  logic            start;
  logic [5:0]      funct;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct, rdata1, rdata2,
    input  busy, stall, done, hi, lo, result
  );

  modport slave (
    input  start, funct, rdata1, rdata2,
    output busy, stall, done, hi, lo, result
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Divide path is built only with MULDIV_DIV_EN.
module muldiv_step #(
  parameter int XLEN = muldiv_seq_pkg::XLEN_D
) (
`ifdef MULDIV_DIV_EN
  input  logic              div,
`endif
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_n
);

  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mul_n;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     top;
  logic [XLEN-1:0]   diff;
  logic              ok;
`endif

  always_comb begin
    sum   = {1'b0, acc[2*XLEN-1:XLEN]}
          + ({1'b0, opb} & {(XLEN+1){acc[0]}});
    mul_n = {sum, acc[XLEN-1:1]};
    acc_n = mul_n;
`ifdef MULDIV_DIV_EN
    // top holds the shifted partial remainder with the next dividend bit
    top  = acc[2*XLEN-1:XLEN-1];
    ok   = top >= {1'b0, opb};
    diff = top[XLEN-1:0] - opb;
    if (div) begin
      acc_n = {ok ? diff : top[XLEN-1:0],
               acc[XLEN-2:0], ok};
    end
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO/MFHI/MFLO.
// Define MULDIV_DIV_EN to build the divide state and datapath.
module muldiv_seq
  import muldiv_seq_pkg::*;
  import common_param::*;
#(
  parameter int XLEN = XLEN_D
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_n;
  logic [XLEN-1:0]   opb;
  logic              neg_lo;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              done_q;
`ifdef MULDIV_DIV_EN
  logic              neg_hi;
  logic              dz;
  logic              op_div;
`endif

  logic              go, is_mul, is_div, is_sgn;
  logic              s1, s2;
  logic [XLEN-1:0]   amag, bmag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign go     = bus.start & (state == IDLE);
  assign is_mul = (bus.funct == F_MULT) | (bus.funct == F_MULTU);
  assign is_div = (bus.funct == F_DIV) | (bus.funct == F_DIVU);
  assign is_sgn = (bus.funct == F_MULT) | (bus.funct == F_DIV);
  assign s1     = is_sgn & bus.rdata1[XLEN-1];
  assign s2     = is_sgn & bus.rdata2[XLEN-1];
  assign amag   = s1 ? -bus.rdata1 : bus.rdata1;
  assign bmag   = s2 ? -bus.rdata2 : bus.rdata2;

  muldiv_step #(.XLEN(XLEN)) u_step (
`ifdef MULDIV_DIV_EN
    .div   (op_div),
`endif
    .acc   (acc),
    .opb   (opb),
    .acc_n (acc_n)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (go) begin
          unique case (1'b1)
            is_mul:  state_n = MUL;
`ifdef MULDIV_DIV_EN
            is_div:  state_n = DIV;
`endif
            default: state_n = IDLE;
          endcase
        end
      end
      MUL: if (cnt == LAST) state_n = FIX;
`ifdef MULDIV_DIV_EN
      DIV: if (cnt == LAST) state_n = FIX;
`endif
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Magnitude result is sign-corrected here, one cycle before HI/LO update
  always_comb begin
    prod   = neg_lo ? -acc : acc;
    fix_hi = prod[2*XLEN-1:XLEN];
    fix_lo = prod[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    if (op_div) begin
      fix_lo = dz ? '1
             : (neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
      fix_hi = neg_hi ? -acc[2*XLEN-1:XLEN]
             : acc[2*XLEN-1:XLEN];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      neg_lo <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_hi <= 1'b0;
      dz     <= 1'b0;
      op_div <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      if (go) begin
        if (bus.funct == F_MTHI) begin
          hi_q   <= bus.rdata2;
          done_q <= 1'b1;
        end
        if (bus.funct == F_MTLO) begin
          lo_q   <= bus.rdata2;
          done_q <= 1'b1;
        end
        if (is_mul) begin
          acc    <= {{XLEN{1'b0}}, bmag};
          opb    <= amag;
          neg_lo <= s1 ^ s2;
          cnt    <= '0;
`ifdef MULDIV_DIV_EN
          op_div <= 1'b0;
`endif
        end
`ifdef MULDIV_DIV_EN
        if (is_div) begin
          acc    <= {{XLEN{1'b0}}, amag};
          opb    <= bmag;
          neg_lo <= s1 ^ s2;
          neg_hi <= s1;
          dz     <= (bus.rdata2 == '0);
          op_div <= 1'b1;
          cnt    <= '0;
        end
`else
        if (is_div) done_q <= 1'b1;
`endif
      end
      if (state == MUL
`ifdef MULDIV_DIV_EN
          || state == DIV
`endif
         ) begin
        acc <= acc_n;
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.stall  = bus.start & bus.busy;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = (bus.funct == F_MFHI) ? hi_q
                    : (bus.funct == F_MFLO) ? lo_q
                    : '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against a plain-arithmetic model.
// Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_seq;
  import common_param::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void model(
    input logic [5:0] f, input logic [31:0] a, b,
    inout logic [31:0] h, inout logic [31:0] l);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT: begin
        p = sa * sb;
        h = p[63:32];
        l = p[31:0];
      end
      F_MULTU: begin
        u = {32'd0, a} * {32'd0, b};
        h = u[63:32];
        l = u[31:0];
      end
`ifdef MULDIV_DIV_EN
      F_DIV: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else begin
          p = sa / sb;
          l = p[31:0];
          p = sa % sb;
          h = p[31:0];
        end
      end
      F_DIVU: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
`endif
      F_MTHI: h = b;
      F_MTLO: l = b;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Presents one op for one edge, then waits (bounded) for done.
  task automatic issue(
    input logic [5:0] f, input logic [31:0] a, b,
    output int cyc, output int busy_n, output bit got);
    bus.start  = 1'b1;
    bus.funct  = f;
    bus.rdata1 = a;
    bus.rdata2 = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0;
    busy_n = 0;
    got = 1'b0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        cyc = i;
      end else if (bus.busy) begin
        busy_n++;
      end
    end
    model(f, a, b, m_hi, m_lo);
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.funct  = F_MFHI;
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_hilo got=%h/%h exp=0/0",
               bus.hi, bus.lo);
    end
    checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'h0) begin
      failures++;
      $display("FAIL reset_out stall=%b result=%h exp=0/0",
               bus.stall, bus.result);
    end
  endtask

  task automatic test_multu_max();
    int cyc, bn;
    bit got;
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bn, got);
    checks++;
    if (!got || cyc != 34) begin
      failures++;
      $display("FAIL multu_latency got=%0d exp=34", cyc);
    end
    checks++;
    if (bn != 33 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL multu_busy got=%0d/%b exp=33/0",
               bn, bus.busy);
    end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h1) begin
      failures++;
      $display("FAIL multu_max got=%h/%h exp=fffffffe/00000001",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_mult_mthi();
    int cyc, bn;
    bit got;
    issue(F_MULT, -32'sd3, 32'd7, cyc, bn, got);
    checks++;
    if (!got || bus.hi !== 32'hFFFF_FFFF
        || bus.lo !== 32'hFFFF_FFEB) begin
      failures++;
      $display("FAIL mult_neg got=%h/%h exp=ffffffff/ffffffeb",
               bus.hi, bus.lo);
    end
    bus.start  = 1'b1;
    bus.funct  = F_MTHI;
    bus.rdata2 = 32'h1234;
    @(posedge clk);
    #1 bus.funct = F_MFHI;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi_done got=%b/%b exp=1/0",
               bus.done, bus.busy);
    end
    checks++;
    if (bus.result !== 32'h1234) begin
      failures++;
      $display("FAIL mfhi_result got=%h exp=00001234",
               bus.result);
    end
    bus.start = 1'b0;
    m_hi = 32'h1234;
  endtask

  task automatic test_div();
    int cyc, bn;
    bit got;
    logic [31:0] eh, el;
`ifdef MULDIV_DIV_EN
    issue(F_DIV, -32'sd7, 32'd2, cyc, bn, got);
    checks++;
    if (!got || cyc != 34 || bus.lo !== 32'hFFFF_FFFD
        || bus.hi !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_neg got=%h/%h cyc=%0d exp=ffffffff/fffffffd",
               bus.hi, bus.lo, cyc);
    end
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bn, got);
    checks++;
    if (!got || bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
      failures++;
      $display("FAIL div_ovf got=%h/%h exp=00000000/80000000",
               bus.hi, bus.lo);
    end
    issue(F_DIVU, 32'd5, 32'd0, cyc, bn, got);
    checks++;
    if (!got || cyc != 34 || bus.hi !== 32'd5
        || bus.lo !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL divu_zero got=%h/%h cyc=%0d exp=5/ffffffff",
               bus.hi, bus.lo, cyc);
    end
`else
    eh = m_hi;
    el = m_lo;
    issue(F_DIV, -32'sd7, 32'd2, cyc, bn, got);
    checks++;
    if (!got || cyc != 1 || bn != 0) begin
      failures++;
      $display("FAIL div_nop_timing got=%0d/%0d exp=1/0", cyc, bn);
    end
    checks++;
    if (bus.hi !== eh || bus.lo !== el) begin
      failures++;
      $display("FAIL div_nop_hilo got=%h/%h exp=%h/%h",
               bus.hi, bus.lo, eh, el);
    end
    issue(F_DIVU, 32'd5, 32'd0, cyc, bn, got);
    checks++;
    if (!got || cyc != 1 || bus.hi !== eh || bus.lo !== el) begin
      failures++;
      $display("FAIL divu_nop got=%h/%h cyc=%0d exp=%h/%h",
               bus.hi, bus.lo, cyc, eh, el);
    end
`endif
  endtask

  task automatic test_mflo_stall();
    int bad, cyc;
    bit got;
    bad = 0;
    cyc = 0;
    got = 1'b0;
    bus.start  = 1'b1;
    bus.funct  = F_MULTU;
    bus.rdata1 = 32'd6;
    bus.rdata2 = 32'd7;
    @(posedge clk);
    #1 bus.funct = F_MFLO;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        cyc = i;
        checks++;
        if (bus.stall !== 1'b0 || bus.result !== 32'd42) begin
          failures++;
          $display("FAIL mflo_done stall=%b result=%h exp=0/0000002a",
                   bus.stall, bus.result);
        end
      end else if (bus.stall !== 1'b1) begin
        bad++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (!got || bad != 0 || cyc != 34) begin
      failures++;
      $display("FAIL mflo_stall gaps=%0d cyc=%0d exp=0/34", bad, cyc);
    end
    model(F_MULTU, 32'd6, 32'd7, m_hi, m_lo);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    bus.start  = 1'b1;
    bus.funct  = F_MULT;
    bus.rdata1 = $urandom | 32'h1;
    bus.rdata2 = $urandom | 32'h1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0
        || bus.lo !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid busy=%b hi=%h lo=%h exp=0/0/0",
               bus.busy, bus.hi, bus.lo);
    end
    for (int i = 0; i < 60; i++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_mid_done got=%0d exp=0", seen);
    end
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_back_to_back();
    int cyc, bn;
    bit got;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    issue(F_MULTU, a, b, cyc, bn, got);
    checks++;
    if (!got || bus.hi !== m_hi || bus.lo !== m_lo) begin
      failures++;
      $display("FAIL b2b_first got=%h/%h exp=%h/%h",
               bus.hi, bus.lo, m_hi, m_lo);
    end
    a = $urandom;
    b = $urandom;
    issue(F_MULT, a, b, cyc, bn, got);
    checks++;
    if (!got || cyc != 34 || bus.hi !== m_hi
        || bus.lo !== m_lo) begin
      failures++;
      $display("FAIL b2b_second got=%h/%h cyc=%0d exp=%h/%h",
               bus.hi, bus.lo, cyc, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] f;
    logic [31:0] a, b;
    int cyc, bn, exp_cyc;
    bit got;
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    for (int n = 0; n < 60; n++) begin
      f = ops[$urandom_range(0, 5)];
      a = rnd_op();
      b = rnd_op();
      exp_cyc = (f == F_MULT || f == F_MULTU) ? 34 : 1;
`ifdef MULDIV_DIV_EN
      if (f == F_DIV || f == F_DIVU) exp_cyc = 34;
`endif
      issue(f, a, b, cyc, bn, got);
      checks++;
      if (!got || cyc != exp_cyc) begin
        failures++;
        $display("FAIL rnd_lat op=%h got=%0d exp=%0d",
                 f, cyc, exp_cyc);
      end
      checks++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        failures++;
        $display("FAIL rnd_hilo op=%h a=%h b=%h got=%h/%h exp=%h/%h",
                 f, a, b, bus.hi, bus.lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_mthi();
    test_div();
    test_mflo_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
